// File: rtl/branch_hazard_controller.sv
// ID-stage branch resolution for the pipelined MIPS core: operand hazard stalls,
// comparator forwarding selects, PC redirect / IF/ID flush and branch statistics.
module branch_hazard_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        Zero,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  output logic        Stall,
  output logic        PCSrc,
  output logic        Flush_IFID,
  output logic        ForwardA_ID,
  output logic        ForwardB_ID,
  output logic [31:0] BranchCount,
  output logic [31:0] TakenCount
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t     state, stateNext;
  logic       cnt, cntNext;
  logic       branch;
  logic       exMatch, memMatch;
  logic [1:0] stallsNeeded;
  logic       resolve;

  function automatic logic dependsOn(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  assign branch   = BranchEQ | BranchNE;
  assign exMatch  = dependsOn(EX_WriteReg, ID_Rs, ID_Rt);
  assign memMatch = dependsOn(MEM_WriteReg, ID_Rs, ID_Rt);

  // Comparator bypass from EX/MEM ALU result; loads in MEM are stalled instead.
  assign ForwardA_ID = MEM_RegWrite & ~MEM_MemRead & (MEM_WriteReg != 5'd0) &
                       (MEM_WriteReg == ID_Rs);
  assign ForwardB_ID = MEM_RegWrite & ~MEM_MemRead & (MEM_WriteReg != 5'd0) &
                       (MEM_WriteReg == ID_Rt);

  always_comb begin
    stallsNeeded = 2'd0;
    if (branch) begin
      if (EX_MemRead & EX_RegWrite & exMatch)
        stallsNeeded = 2'd2;
      else if (EX_RegWrite & ~EX_MemRead & exMatch)
        stallsNeeded = 2'd1;
      else if (MEM_MemRead & MEM_RegWrite & memMatch)
        stallsNeeded = 2'd1;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext  = state;
    cntNext    = 1'b0;
    Stall      = 1'b0;
    PCSrc      = 1'b0;
    resolve    = 1'b0;
    unique case (state)
      IDLE: begin
        if (stallsNeeded != 2'd0) begin
          Stall = 1'b1;
          if (stallsNeeded == 2'd2) begin
            stateNext = STALL;
            cntNext   = 1'b1;
          end
        end else if (branch) begin
          resolve = 1'b1;
          // Both opcodes asserted decodes as BEQ.
          PCSrc   = (BranchEQ & Zero) | (~BranchEQ & BranchNE & ~Zero);
        end
      end
      STALL: begin
        Stall     = 1'b1;
        stateNext = IDLE;
        if (cnt) cntNext = cnt - 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign Flush_IFID = PCSrc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 1'b0;
      BranchCount <= 32'd0;
      TakenCount  <= 32'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (resolve) begin
        BranchCount <= BranchCount + 32'd1;
        if (PCSrc) TakenCount <= TakenCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed plus randomized check of branch_hazard_controller against a
// cycle-count reference model of the stall/resolve rules.
module tb_branch_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        BranchEQ, BranchNE, Zero;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        EX_RegWrite, EX_MemRead;
  logic [4:0]  EX_WriteReg;
  logic        MEM_RegWrite, MEM_MemRead;
  logic [4:0]  MEM_WriteReg;
  logic        Stall, PCSrc, Flush_IFID, ForwardA_ID, ForwardB_ID;
  logic [31:0] BranchCount, TakenCount;

  branch_hazard_controller dut (
    .clk(clk), .reset(reset),
    .BranchEQ(BranchEQ), .BranchNE(BranchNE), .Zero(Zero),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
    .Stall(Stall), .PCSrc(PCSrc), .Flush_IFID(Flush_IFID),
    .ForwardA_ID(ForwardA_ID), .ForwardB_ID(ForwardB_ID),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Reference model: forced stall cycles still owed, and the two counters.
  int          owedStalls;
  logic [31:0] modelBranches, modelTaken;
  int          pendOwed;
  bit          pendResolve, pendTaken;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int stallsFor();
    bit exHit, memHit;
    if (!(BranchEQ || BranchNE)) return 0;
    exHit  = EX_WriteReg != 0 && (EX_WriteReg == ID_Rs || EX_WriteReg == ID_Rt);
    memHit = MEM_WriteReg != 0 && (MEM_WriteReg == ID_Rs || MEM_WriteReg == ID_Rt);
    if (EX_RegWrite && exHit) return EX_MemRead ? 2 : 1;
    if (MEM_RegWrite && MEM_MemRead && memHit) return 1;
    return 0;
  endfunction

  task automatic setIn(input bit eq, input bit ne, input bit z,
                       input int rs, input int rt,
                       input bit exRw, input bit exMr, input int exWr,
                       input bit memRw, input bit memMr, input int memWr);
    BranchEQ = eq;  BranchNE = ne;  Zero = z;
    ID_Rs = 5'(rs); ID_Rt = 5'(rt);
    EX_RegWrite = exRw;   EX_MemRead = exMr;   EX_WriteReg = 5'(exWr);
    MEM_RegWrite = memRw; MEM_MemRead = memMr; MEM_WriteReg = 5'(memWr);
  endtask

  task automatic setReset(input bit v);
    reset = v;
    if (v) begin
      owedStalls    = 0;
      modelBranches = 32'd0;
      modelTaken    = 32'd0;
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic step(input string tag);
    int  n;
    bit  expStall, expPc, fwdA, fwdB;
    @(negedge clk);
    pendResolve = 1'b0;
    pendTaken   = 1'b0;
    if (owedStalls > 0) begin
      expStall = 1'b1;
      pendOwed = owedStalls - 1;
    end else begin
      n        = stallsFor();
      expStall = n > 0;
      pendOwed = n > 0 ? n - 1 : 0;
      pendResolve = (BranchEQ || BranchNE) && n == 0;
      pendTaken   = pendResolve && (BranchEQ ? Zero : !Zero);
    end
    expPc = pendTaken;
    fwdA  = MEM_RegWrite && !MEM_MemRead && MEM_WriteReg != 0 && MEM_WriteReg == ID_Rs;
    fwdB  = MEM_RegWrite && !MEM_MemRead && MEM_WriteReg != 0 && MEM_WriteReg == ID_Rt;
    check({tag, ".Stall"}, 32'(Stall), 32'(expStall));
    check({tag, ".PCSrc"}, 32'(PCSrc), 32'(expPc));
    check({tag, ".Flush"}, 32'(Flush_IFID), 32'(expPc));
    check({tag, ".FwdA"},  32'(ForwardA_ID), 32'(fwdA));
    check({tag, ".FwdB"},  32'(ForwardB_ID), 32'(fwdB));
    check({tag, ".BrCnt"}, BranchCount, modelBranches);
    check({tag, ".TkCnt"}, TakenCount, modelTaken);
    @(posedge clk);
    if (!reset) begin
      owedStalls = pendOwed;
      if (pendResolve) modelBranches = modelBranches + 32'd1;
      if (pendTaken)   modelTaken    = modelTaken + 32'd1;
    end
    #1;
  endtask

  task automatic idle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    setReset(1'b1);
    idle();
    step("reset");
    setReset(1'b0);

    // Hazard-free taken BEQ, then counters one cycle later.
    setIn(1, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    step("beq_free");
    idle();
    step("beq_free_cnt");

    // BNE behind an EX load: two stall cycles, then resolve taken.
    setIn(0, 1, 0, 5, 0, 1, 1, 5, 0, 0, 0);
    step("bne_load_s1");
    step("bne_load_s2");
    setIn(0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    step("bne_load_res");
    idle();
    step("bne_load_cnt");

    // BEQ behind an EX ALU write: one stall, then forwarded from MEM.
    setIn(1, 0, 0, 0, 7, 1, 0, 7, 0, 0, 0);
    step("beq_alu_s1");
    setIn(1, 0, 0, 0, 7, 0, 0, 0, 1, 0, 7);
    step("beq_alu_fwd");

    // Register 0 never creates a dependency.
    setIn(1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    step("r0");

    // Reset in the middle of a two-cycle stall.
    setIn(0, 1, 1, 9, 0, 1, 1, 9, 0, 0, 0);
    step("abort_s1");
    idle();
    setReset(1'b1);
    step("abort_rst");
    setReset(1'b0);
    setIn(1, 0, 1, 4, 6, 0, 0, 0, 0, 0, 0);
    step("after_rst");
    idle();
    step("after_rst_cnt");

    // Counter wrap, resolved with both opcodes asserted (decoded as BEQ).
    force dut.BranchCount = 32'hFFFF_FFFF;
    #1 release dut.BranchCount;
    modelBranches = 32'hFFFF_FFFF;
    setIn(1, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0);
    step("wrap_both");
    idle();
    step("wrap_cnt");
    setIn(1, 1, 0, 2, 2, 0, 0, 0, 0, 0, 0);
    step("both_z0");

    // Random traffic over a small register window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      setIn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
      setReset($urandom_range(0, 49) == 0);
      step("rand");
    end
    setReset(1'b0);
    idle();
    step("final");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/branch_hazard_controller.md
# branch_hazard_controller

Resolves conditional branches in the ID stage of the pipelined MIPS core, consuming the single-bit equality result of the ID-stage register comparator. Detects data hazards on the comparator's operands and stalls IF/ID for 1 or 2 cycles. Provides ID-stage forwarding selects, issues PC redirect and IF/ID flush on a taken BEQ/BNE, and keeps resolved/taken branch counters.

## Interface
- No parameters; register-address width fixed at 5, counter width fixed at 32.
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- BranchEQ  in  1  ID instruction is BEQ
- BranchNE  in  1  ID instruction is BNE
- Zero  in  1  comparator output, 1 when forwarded ReadData1 == ReadData2
- ID_Rs, ID_Rt  in  5 each  source registers of the ID instruction
- EX_RegWrite, EX_MemRead  in  1 each  ID/EX control
- EX_WriteReg  in  5  ID/EX destination register
- MEM_RegWrite, MEM_MemRead  in  1 each  EX/MEM control
- MEM_WriteReg  in  5  EX/MEM destination register
- Stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- PCSrc  out  1  select branch target for next PC
- Flush_IFID  out  1  zero IF/ID on next edge
- ForwardA_ID, ForwardB_ID  out  1 each  comparator operand A/B takes EX/MEM ALU result
- BranchCount  out  32  resolved branches
- TakenCount  out  32  taken branches

## Operation
- Branch = BranchEQ | BranchNE. If both are asserted, treat the instruction as BEQ.
- A dependency match on register r requires r != 0 and r ∈ {ID_Rs, ID_Rt}.
- Required stalls n, evaluated combinationally:
  - n = 2 when EX_MemRead & EX_RegWrite and EX_WriteReg matches.
  - Otherwise n = 1 when EX_RegWrite & ~EX_MemRead and EX_WriteReg matches.
  - Otherwise n = 1 when MEM_MemRead & MEM_RegWrite and MEM_WriteReg matches.
  - Otherwise n = 0.
  - n is 0 whenever Branch = 0.
- Forwarding:
  - ForwardA_ID = MEM_RegWrite & ~MEM_MemRead & MEM_WriteReg != 0 & MEM_WriteReg == ID_Rs.
  - ForwardB_ID is the same expression using ID_Rt.
  - Both are combinational and independent of state.
- FSM has two states, IDLE and STALL, plus a 1-bit remaining-stall counter cnt.
  - IDLE with n = 0: Stall = 0. The branch resolves this cycle.
  - IDLE with n = 1: Stall = 1. Stay in IDLE, cnt <= 0.
  - IDLE with n = 2: Stall = 1. Go to STALL, cnt <= 1.
  - STALL: Stall = 1 regardless of inputs, cnt <= 0, next state IDLE. Hazard inputs are ignored in this state.
- Hazard re-evaluation: after a stall the FSM returns to IDLE and re-evaluates n. Inserted bubbles normally make n = 0; any residual hazard re-stalls.
- Resolution cycle (state IDLE, Branch = 1, n = 0):
  - PCSrc = (BranchEQ & Zero) | (~BranchEQ & BranchNE & ~Zero).
  - Flush_IFID = PCSrc.
  - BranchCount increments by 1; TakenCount increments by 1 when PCSrc = 1.
  - Counters wrap at 2^32 (0xFFFFFFFF + 1 = 0).
- Outside the resolution cycle, PCSrc = Flush_IFID = 0 and counters hold. A branch is counted exactly once regardless of stall length.
- Reset:
  - Forces state IDLE, cnt = 0, BranchCount = TakenCount = 0 immediately.
  - Reset asserted mid-STALL aborts the stall.
  - Combinational outputs follow their inputs while reset is asserted, except Stall's STALL term, which is 0.

## Timing
- Stall, PCSrc, Flush_IFID, ForwardA_ID and ForwardB_ID are combinational from inputs and state, valid within the same cycle.
- State, cnt and counters update on the rising clk edge.
- Counter values are visible the cycle after resolution.
- Latency from branch entering ID to PCSrc valid:
  - 0 cycles with no hazard.
  - 1 cycle for an EX ALU hazard or MEM load hazard.
  - 2 cycles for an EX load hazard.
- Output values during reset: Stall = 0 unless n ≠ 0; counters 0.

## Test plan
- Reset then BEQ with Rs = Rt = 3, no hazards, Zero = 1:
  - Same cycle: Stall = 0, PCSrc = 1, Flush_IFID = 1.
  - Next cycle: BranchCount = 1, TakenCount = 1.
- BNE with Rs = 5, EX_MemRead = EX_RegWrite = 1, EX_WriteReg = 5:
  - Stall high 2 cycles.
  - Then, with hazards cleared and Zero = 0: PCSrc = 1, counters increment once.
- BEQ with Rt = 7, EX ALU writes 7: Stall for 1 cycle. Then, with MEM ALU writing 7, Stall = 0 and ForwardB_ID = 1.
- EX_WriteReg = 0 with EX_MemRead = EX_RegWrite = 1 and Rs = 0 -> no stall, ForwardA_ID = 0.
- Assert reset during STALL -> Stall drops immediately, counters 0, next branch resolves normally.
- Preload BranchCount to 0xFFFFFFFF via repeated branches (or force) -> after one more resolved branch, BranchCount = 0. Also check BranchEQ = BranchNE = 1 with Zero = 1 -> PCSrc = 1.
